// File: rtl/collatz_host_seq.sv
// Host sequencer for the Collatz core pin protocol: writes a start value
// byte-wise, pulses GO, waits for COMPUTE to finish, reads back the result.
// Ports: clk/reset (sync, active-high); cmd_* start-value handshake;
// res_* result handshake; core_* pin-level link to the accelerator core.
module collatz_host_seq #(
  parameter int START_BYTES = 18,
  parameter int TIMEOUT_W = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'h10_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [8*START_BYTES-1:0] cmd_start,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [15:0]              res_orbit_len,
  output logic [15:0]              res_path_h16,
  output logic                     res_timeout,
  output logic [7:0]               core_ui_in,
  output logic [7:0]               core_uio_in,
  input  logic [7:0]               core_uo_out,
  input  logic [7:0]               core_uio_out,
  input  logic [7:0]               core_uio_oe
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_GO,
    S_WAIT_ENTER,
    S_WAIT_DONE,
    S_READ,
    S_RESULT
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(START_BYTES - 1);
  localparam logic [TIMEOUT_W-1:0] WD_LAST =
    TIMEOUT_CYCLES - {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  state_t state, state_d;
  logic [8*START_BYTES-1:0] start_q;
  logic [4:0] idx;
  logic [2:0] rcnt;
  logic [TIMEOUT_W-1:0] wdog;
  logic [15:0] orbit_q;
  logic [15:0] path_q;
  logic tmo_q;
  logic in_compute;
  logic wd_hit;

  // Busy status is debug-only; completion is judged from the oe bit.
  logic unused_ok;
  assign unused_ok = ^{core_uio_out, core_uio_oe[6:0]};

  assign in_compute = core_uio_oe[7];
  assign wd_hit = (wdog == WD_LAST);

  assign res_orbit_len = orbit_q;
  assign res_path_h16 = path_q;
  assign res_timeout = tmo_q;

  always_comb begin
    state_d = state;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    core_uio_in = 8'h00;
    core_ui_in = 8'h00;
    unique case (state)
      S_IDLE: begin
        cmd_ready = !in_compute;
        if (cmd_valid && cmd_ready) state_d = S_WRITE;
      end
      S_WRITE: begin
        core_uio_in = {3'b100, idx};
        core_ui_in = start_q[{idx, 3'b000} +: 8];
        if (idx == LAST_IDX) state_d = S_GO;
      end
      S_GO: begin
        core_uio_in = 8'h40;
        state_d = S_WAIT_ENTER;
      end
      S_WAIT_ENTER: begin
        if (in_compute) state_d = S_WAIT_DONE;
        else if (wd_hit) state_d = S_RESULT;
      end
      S_WAIT_DONE: begin
        if (!in_compute) state_d = S_READ;
        else if (wd_hit) state_d = S_RESULT;
      end
      S_READ: begin
        unique case (rcnt)
          3'd0: core_uio_in = 8'h00;
          3'd1: core_uio_in = 8'h01;
          3'd2: core_uio_in = 8'h20;
          3'd3: core_uio_in = 8'h21;
          default: core_uio_in = 8'h00;
        endcase
        if (rcnt == 3'd4) state_d = S_RESULT;
      end
      S_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      start_q <= '0;
      idx <= '0;
      rcnt <= '0;
      wdog <= '0;
      orbit_q <= '0;
      path_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      state <= state_d;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            start_q <= cmd_start;
            idx <= '0;
          end
        end
        S_WRITE: idx <= idx + 5'd1;
        S_GO: begin
          wdog <= '0;
          rcnt <= '0;
        end
        S_WAIT_ENTER, S_WAIT_DONE: begin
          wdog <= wdog + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
          if (state_d == S_RESULT) begin
            tmo_q <= 1'b1;
            orbit_q <= '0;
            path_q <= '0;
          end
        end
        S_READ: begin
          rcnt <= rcnt + 3'd1;
          // Read data lags its address by one cycle.
          unique case (rcnt)
            3'd0: tmo_q <= 1'b0;
            3'd1: orbit_q[7:0] <= core_uo_out;
            3'd2: orbit_q[15:8] <= core_uo_out;
            3'd3: path_q[7:0] <= core_uo_out;
            3'd4: path_q[15:8] <= core_uo_out;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
